// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and microsecond-to-cycle helper for button_press_decoder
package btn_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, GAP} btn_state_t;
   function automatic int us_to_cycles(input int us, input int clk_per);
      return us * 1000 / clk_per;
   endfunction
endpackage

// File: rtl/button_press_decoder.sv
// button_press_decoder: turns a debounced button level into step pulses with long-press, auto-repeat and double-click
// Ports:
//    clk          system clock
//    CPU_RESETN   asynchronous active-low reset
//    btn_level    debounced button level, 1 = pressed
//    step         one-cycle pulse per press / repeat step
//    long_press   high while the press is beyond the hold time
//    double_click one-cycle pulse on a qualifying second press
// Optional feature: define BTN_AUTOREPEAT_EN to emit repeat steps while a long press is held.
module button_press_decoder
   import btn_pkg::*;
#(
   parameter int CLK_PER   = 10,
   parameter int HOLD_US   = 500000,
   parameter int REPEAT_US = 100000,
   parameter int DCLICK_US = 250000
) (
   input  logic clk,
   input  logic CPU_RESETN,
   input  logic btn_level,
   output logic step,
   output logic long_press,
   output logic double_click
);
   localparam int HOLD_CYC   = us_to_cycles(HOLD_US, CLK_PER);
   localparam int REPEAT_CYC = us_to_cycles(REPEAT_US, CLK_PER);
   localparam int DCLICK_CYC = us_to_cycles(DCLICK_US, CLK_PER);
   localparam int HD_CYC     = HOLD_CYC > DCLICK_CYC ? HOLD_CYC : DCLICK_CYC;
`ifdef BTN_AUTOREPEAT_EN
   localparam int MAX_CYC    = HD_CYC > REPEAT_CYC ? HD_CYC : REPEAT_CYC;
`else
   localparam int MAX_CYC    = HD_CYC;
`endif
   localparam int TW         = $clog2(MAX_CYC + 1);

   if (HOLD_CYC < 2 || REPEAT_CYC < 2 || DCLICK_CYC < 2) begin : g_cyc_check
      $error("button_press_decoder: HOLD/REPEAT/DCLICK cycle counts must be >= 2");
   end

   btn_state_t    state;
   logic [TW-1:0] timer;
   logic          prev_level;
   logic          dbl_done;
   logic          rise;
   logic          fall;

   assign rise = btn_level & ~prev_level;
   assign fall = ~btn_level & prev_level;

   // Timer saturates; every state change (and every repeat step) restarts it from 0.
   always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state        <= IDLE;
         timer        <= '0;
         prev_level   <= 1'b0;
         dbl_done     <= 1'b0;
         step         <= 1'b0;
         long_press   <= 1'b0;
         double_click <= 1'b0;
      end else begin
         prev_level   <= btn_level;
         step         <= 1'b0;
         double_click <= 1'b0;
         if (timer != '1) timer <= timer + TW'(1);
         case (state)
            IDLE: if (rise) begin
               step     <= 1'b1;
               dbl_done <= 1'b0;
               state    <= HOLD;
               timer    <= '0;
            end
            // Fall is tested first so a release on the expiry cycle stays a short press.
            HOLD: if (fall) begin
               state <= dbl_done ? IDLE : GAP;
               timer <= '0;
            end else if (timer == TW'(HOLD_CYC - 1)) begin
               long_press <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
               step       <= 1'b1;
`endif
               state      <= REPEAT;
               timer      <= '0;
            end
            REPEAT: if (fall) begin
               long_press <= 1'b0;
               state      <= IDLE;
               timer      <= '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (timer == TW'(REPEAT_CYC - 1)) begin
               step  <= 1'b1;
               timer <= '0;
            end
`endif
            // Rise is tested first so a re-press on the timeout cycle still counts.
            GAP: if (rise) begin
               step         <= 1'b1;
               double_click <= 1'b1;
               dbl_done     <= 1'b1;
               state        <= HOLD;
               timer        <= '0;
            end else if (timer == TW'(DCLICK_CYC - 1)) begin
               state <= IDLE;
               timer <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_button_press_decoder.sv
// tb_button_press_decoder: directed self-checking bench for button_press_decoder
module tb_button_press_decoder;
   import btn_pkg::*;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn = 1'b0;
   logic step, long_press, double_click;
   int checks = 0;
   int errors = 0;
   int nstep = 0, nlp = 0, ndc = 0;

   button_press_decoder #(.CLK_PER(10), .HOLD_US(2), .REPEAT_US(1), .DCLICK_US(1)) dut (
      .clk(clk), .CPU_RESETN(rst_n), .btn_level(btn),
      .step(step), .long_press(long_press), .double_click(double_click)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) begin
         @(negedge clk);
         nstep += int'(step);
         nlp   += int'(long_press);
         ndc   += int'(double_click);
      end
   endtask

   task automatic clr();
      nstep = 0; nlp = 0; ndc = 0;
   endtask

   initial begin
      #1;
      chk("rst_step", step, 0);
      chk("rst_lp", long_press, 0);
      chk("rst_dc", double_click, 0);
      @(negedge clk);
      rst_n = 1'b1;
      adv(3);
      // 1: short press, single step
      clr(); btn = 1'b1;
      adv(1); chk("t1_step", step, 1);
      adv(49); btn = 1'b0;
      adv(200);
      chk("t1_nstep", nstep, 1);
      chk("t1_nlp", nlp, 0);
      chk("t1_ndc", ndc, 0);
      // 2: long press held 450 cycles
      clr(); btn = 1'b1;
      adv(1); chk("t2_step0", step, 1);
      adv(199); chk("t2_lp_early", long_press, 0);
      adv(1); chk("t2_lp_on", long_press, 1); chk("t2_step200", step, int'(AR));
      adv(99); chk("t2_step299", step, 0);
      adv(1); chk("t2_step300", step, int'(AR));
      adv(100); chk("t2_step400", step, int'(AR));
      adv(49); chk("t2_lp_held", long_press, 1);
      btn = 1'b0;
      adv(1); chk("t2_lp_off", long_press, 0);
      chk("t2_nstep", nstep, AR ? 4 : 1);
      chk("t2_nlp", nlp, 250);
      adv(5);
      // 3: double click, then third press is plain
      clr(); btn = 1'b1;
      adv(1); chk("t3_step1", step, 1);
      adv(19); btn = 1'b0;
      adv(30); btn = 1'b1;
      adv(1); chk("t3_step2", step, 1); chk("t3_dc2", double_click, 1);
      adv(1); chk("t3_dc_pulse", double_click, 0);
      adv(18); btn = 1'b0;
      adv(30); btn = 1'b1;
      adv(1); chk("t3_step3", step, 1); chk("t3_dc3", double_click, 0);
      adv(19); btn = 1'b0;
      adv(200);
      chk("t3_ndc", ndc, 1);
      chk("t3_nstep", nstep, 3);
      // 4: re-press after gap timed out
      clr(); btn = 1'b1;
      adv(20); btn = 1'b0;
      adv(150); btn = 1'b1;
      adv(1); chk("t4_step", step, 1); chk("t4_dc", double_click, 0);
      adv(19); btn = 1'b0;
      adv(200);
      chk("t4_ndc", ndc, 0);
      // 5: fall on hold expiry, rise on gap timeout
      clr(); btn = 1'b1;
      adv(200); btn = 1'b0;
      adv(1); chk("t5_lp", long_press, 0);
      chk("t5_state", int'(dut.state), int'(GAP));
      adv(99); btn = 1'b1;
      adv(1); chk("t5_dc", double_click, 1); chk("t5_step", step, 1);
      adv(19); btn = 1'b0;
      adv(5);
      chk("t5_nlp", nlp, 0);
      // 6: async reset mid-repeat with button held through release
      clr(); btn = 1'b1;
      adv(251); chk("t6_lp_pre", long_press, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_lp", long_press, 0);
      chk("t6_async_step", step, 0);
      chk("t6_async_dc", double_click, 0);
      adv(2);
      rst_n = 1'b1;
      adv(1); chk("t6_step", step, 1);
      adv(199); chk("t6_lp_early", long_press, 0);
      adv(1); chk("t6_lp_on", long_press, 1);
      btn = 1'b0;
      adv(1); chk("t6_lp_off", long_press, 0);
      adv(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
